pe_pipelined: RTL and testbench

Parametrised pipelined processing element for the PEA array: the successor to the fixed-width basic PE. It takes a 13-bit instruction word and operands from the four mesh neighbours (E/S/W/N), two local registers or the previous result. It computes through a LAT-stage pipeline and writes to one neighbour output, all four outputs, a local register or the memory port. Unlike the basic PE, it adds valid/ack backpressure, so a slow consumer freezes the pipeline without losing results.

---
 rtl/pe_pipelined.sv | 150 +++++++++++++++
 tb/tb_pe_pipelined.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_pipelined.sv
// pe_pipelined: pipelined mesh processing element with valid/ack backpressure.
// Optional feature macro: PE_MUL_EN (enables the DW x DW multiplier for opcode 2;
// without it opcode 2 retires as a NOP).
module pe_pipelined #(
    parameter int unsigned DW  = 32,
    parameter int unsigned LAT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [12:0]   ctrl,
    input  logic [DW-1:0] E,
    input  logic [DW-1:0] S,
    input  logic [DW-1:0] W,
    input  logic [DW-1:0] N,
    input  logic          en,
    input  logic          input_ready,
    output logic          input_ack,
    input  logic          out_ack,
    output logic [DW-1:0] OutputE,
    output logic [DW-1:0] OutputS,
    output logic [DW-1:0] OutputW,
    output logic [DW-1:0] OutputN,
    output logic [DW-1:0] Data_memory,
    output logic          output_ready
);

    localparam int unsigned SHW  = $clog2(DW);
    localparam int unsigned LAST = LAT - 1;

    logic [2:0]     dst;
    logic [2:0]     op1;
    logic [2:0]     op2;
    logic [3:0]     opcode;
    logic [DW-1:0]  r0;
    logic [DW-1:0]  r1;
    logic [DW-1:0]  fb;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [DW-1:0]  alu;
    logic           alu_wr;
    logic [SHW-1:0] shamt;
    logic           stall;
    logic           issue;

    // Pipeline stage registers: result is computed at issue and carried with its dst
    logic [LAT-1:0]         vld;
    logic [LAT-1:0]         wr;
    logic [LAT-1:0][DW-1:0] res;
    logic [LAT-1:0][2:0]    dsts;

    assign {dst, op1, op2, opcode} = ctrl;

    assign stall     = output_ready & ~out_ack;
    assign input_ack = ~stall;
    assign issue     = en & input_ready & ~stall;

    function automatic logic [DW-1:0] pick(
        input logic [2:0]    code,
        input logic [DW-1:0] ve, vs, vw, vn, vr0, vr1, vfb
    );
        logic [DW-1:0] v;
        case (code)
            3'd0:    v = ve;
            3'd1:    v = vs;
            3'd2:    v = vw;
            3'd3:    v = vn;
            3'd4:    v = vr0;
            3'd5:    v = vr1;
            3'd6:    v = vfb;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Operand selection and ALU evaluated on the values present at issue
    always_comb begin
        a      = pick(op1, E, S, W, N, r0, r1, fb);
        b      = pick(op2, E, S, W, N, r0, r1, fb);
        shamt  = b[SHW-1:0];
        alu    = '0;
        alu_wr = 1'b1;
        case (opcode)
            4'd0:    alu = a + b;
            4'd1:    alu = a - b;
`ifdef PE_MUL_EN
            4'd2:    alu = a * b;
`endif
            4'd3:    alu = a & b;
            4'd4:    alu = a | b;
            4'd5:    alu = a ^ b;
            4'd6:    alu = a << shamt;
            4'd7:    alu = a >> shamt;
            4'd8:    alu = DW'($signed(a) >>> shamt);
            4'd9:    alu = ($signed(a) < $signed(b)) ? a : b;
            4'd10:   alu = ($signed(a) > $signed(b)) ? a : b;
            4'd11:   alu = a;
            4'd12:   alu = DW'(a == b);
            4'd13:   alu = DW'($signed(a) < $signed(b));
            default: alu_wr = 1'b0;
        endcase
    end

    // Pipeline advance and retirement; everything freezes while stalled
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld          <= '0;
            r0           <= '0;
            r1           <= '0;
            fb           <= '0;
            OutputE      <= '0;
            OutputS      <= '0;
            OutputW      <= '0;
            OutputN      <= '0;
            Data_memory  <= '0;
            output_ready <= 1'b0;
        end else if (!stall) begin
            vld[0]  <= issue;
            wr[0]   <= alu_wr;
            res[0]  <= alu;
            dsts[0] <= dst;
            for (int unsigned i = 1; i < LAT; i++) begin
                vld[i]  <= vld[i-1];
                wr[i]   <= wr[i-1];
                res[i]  <= res[i-1];
                dsts[i] <= dsts[i-1];
            end
            if (out_ack) output_ready <= 1'b0;
            if (vld[LAST] && wr[LAST]) begin
                fb <= res[LAST];
                case (dsts[LAST])
                    3'd0: begin OutputE <= res[LAST]; output_ready <= 1'b1; end
                    3'd1: begin OutputS <= res[LAST]; output_ready <= 1'b1; end
                    3'd2: begin OutputW <= res[LAST]; output_ready <= 1'b1; end
                    3'd3: begin OutputN <= res[LAST]; output_ready <= 1'b1; end
                    3'd4: r0 <= res[LAST];
                    3'd5: r1 <= res[LAST];
                    3'd6: begin Data_memory <= res[LAST]; output_ready <= 1'b1; end
                    default: begin
                        OutputE      <= res[LAST];
                        OutputS      <= res[LAST];
                        OutputW      <= res[LAST];
                        OutputN      <= res[LAST];
                        output_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pe_pipelined.sv
// tb_pe_pipelined: scoreboard bench for pe_pipelined with a program-order reference model.
`timescale 1ns/1ps
module tb_pe_pipelined;

    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 3;
`ifdef PE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [12:0]   ctrl;
    logic [DW-1:0] E, S, W, N;
    logic          en, input_ready, input_ack, out_ack;
    logic [DW-1:0] OutputE, OutputS, OutputW, OutputN, Data_memory;
    logic          output_ready;

    pe_pipelined #(.DW(DW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .ctrl(ctrl),
        .E(E), .S(S), .W(W), .N(N),
        .en(en), .input_ready(input_ready), .input_ack(input_ack),
        .out_ack(out_ack),
        .OutputE(OutputE), .OutputS(OutputS), .OutputW(OutputW), .OutputN(OutputN),
        .Data_memory(Data_memory), .output_ready(output_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    dst;
        logic [DW-1:0] val;
    } exp_t;

    exp_t          sbq[$];
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] m_r0, m_r1, m_fb;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [12:0] mk(input int d, input int o1, input int o2, input int opc);
        return {3'(d), 3'(o1), 3'(o2), 4'(opc)};
    endfunction

    function automatic logic [DW-1:0] srcval(input logic [2:0] c, input logic [DW-1:0] ve, vs, vw, vn);
        case (c)
            3'd0: return ve;
            3'd1: return vs;
            3'd2: return vw;
            3'd3: return vn;
            3'd4: return m_r0;
            3'd5: return m_r1;
            3'd6: return m_fb;
            default: return '0;
        endcase
    endfunction

    // Instruction semantics from the opcode table; returns 0 for instructions that write nothing
    function automatic bit model_op(input logic [3:0] op, input logic [DW-1:0] x, y, output logic [DW-1:0] v);
        int sh;
        sh = int'(y % DW);
        v  = '0;
        case (op)
            4'd0:  v = x + y;
            4'd1:  v = x - y;
            4'd2:  begin v = x * y; return MUL_EN; end
            4'd3:  v = x & y;
            4'd4:  v = x | y;
            4'd5:  v = x ^ y;
            4'd6:  v = x << sh;
            4'd7:  v = x >> sh;
            4'd8:  v = (x >> sh) | (x[DW-1] ? ~({DW{1'b1}} >> sh) : '0);
            4'd9:  v = ($signed(x) < $signed(y)) ? x : y;
            4'd10: v = ($signed(x) > $signed(y)) ? x : y;
            4'd11: v = x;
            4'd12: v = (x == y) ? DW'(1) : '0;
            4'd13: v = ($signed(x) < $signed(y)) ? DW'(1) : '0;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // Program-order reference: every accepted instruction updates the model immediately
    function automatic void model_issue(input logic [12:0] c, input logic [DW-1:0] ve, vs, vw, vn);
        logic [DW-1:0] x, y, v;
        exp_t          ex;
        x = srcval(c[9:7], ve, vs, vw, vn);
        y = srcval(c[6:4], ve, vs, vw, vn);
        if (model_op(c[3:0], x, y, v)) begin
            m_fb = v;
            if (c[12:10] == 3'd4)      m_r0 = v;
            else if (c[12:10] == 3'd5) m_r1 = v;
            else begin
                ex.dst = c[12:10];
                ex.val = v;
                sbq.push_back(ex);
            end
        end
    endfunction

    // One clock of stimulus; acc reports whether the DUT accepted the instruction
    task automatic cyc(input logic ien, input logic rdy, input logic [12:0] c,
                       input logic [DW-1:0] ve, vs, vw, vn, input logic ack, output logic acc);
        en = ien; input_ready = rdy; ctrl = c;
        E = ve; S = vs; W = vw; N = vn; out_ack = ack;
        @(negedge clk);
        acc = en && input_ready && input_ack;
        if (acc) model_issue(c, ve, vs, vw, vn);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ack);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, '0, '0, '0, ack, acc);
    endtask

    task automatic drain();
        idle(int'(LAT) + 2, 1'b1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0; en = 1'b0; input_ready = 1'b0; out_ack = 1'b0;
        sbq.delete();
        m_r0 = '0; m_r1 = '0; m_fb = '0;
        repeat (n) @(posedge clk);
        #1;
        chk1("reset_input_ack", input_ack, 1'b1);
        chk1("reset_output_ready", output_ready, 1'b0);
        reset = 1'b1;
    endtask

    // ADD E+S -> OutputE with exact issue-to-output latency
    task automatic lat_test();
        logic acc;
        cyc(1'b1, 1'b1, mk(0, 0, 1, 0), DW'(1), DW'(2), '0, '0, 1'b1, acc);
        chk1("lat_issue", acc, 1'b1);
        for (int i = 1; i <= int'(LAT); i++) begin
            cyc(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b1, acc);
            if (i < int'(LAT)) chk1("lat_early_ready", output_ready, 1'b0);
        end
        chk1("lat_ready", output_ready, 1'b1);
        chk("lat_OutputE", OutputE, DW'(3));
        chk("lat_OutputS", OutputS, '0);
        chk("lat_OutputW", OutputW, '0);
        chk("lat_OutputN", OutputN, '0);
        chk("lat_Data_memory", Data_memory, '0);
    endtask

    function automatic logic [DW-1:0] rnd_val();
        if ($urandom_range(0, 3) == 0) return DW'($urandom_range(0, 3));
        return DW'($urandom());
    endfunction

    function automatic int ext_src();
        int v;
        v = int'($urandom_range(0, 4));
        return (v == 4) ? 7 : v;
    endfunction

    // Scoreboard monitor: each result accepted by out_ack is compared against the queue head
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (reset && output_ready && out_ack) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: output_ready=1 with empty scoreboard at %0t", $time);
                end else begin
                    x = sbq.pop_front();
                    case (x.dst)
                        3'd0: chk("result_E", OutputE, x.val);
                        3'd1: chk("result_S", OutputS, x.val);
                        3'd2: chk("result_W", OutputW, x.val);
                        3'd3: chk("result_N", OutputN, x.val);
                        3'd6: chk("result_mem", Data_memory, x.val);
                        default: begin
                            chk("result_all_E", OutputE, x.val);
                            chk("result_all_S", OutputS, x.val);
                            chk("result_all_W", OutputW, x.val);
                            chk("result_all_N", OutputN, x.val);
                        end
                    endcase
                end
            end
        end
    end

    initial begin : stim
        logic        acc;
        bit          drained;
        logic [12:0] c;
        int          o1, o2;

        reset = 1'b0; ctrl = '0; E = '0; S = '0; W = '0; N = '0;
        en = 1'b0; input_ready = 1'b0; out_ack = 1'b0;
        m_r0 = '0; m_r1 = '0; m_fb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_output_ready", output_ready, 1'b0);
        chk1("rst_input_ack", input_ack, 1'b1);
        chk("rst_OutputE", OutputE, '0);
        chk("rst_OutputN", OutputN, '0);
        chk("rst_Data_memory", Data_memory, '0);
        reset = 1'b1;
        #1;
        chk1("post_rst_input_ack", input_ack, 1'b1);

        lat_test();
        drain();

        // Backpressure: four external results with no acknowledge
        cyc(1'b1, 1'b1, mk(1, 0, 1, 1), DW'(10), DW'(3), '0, '0, 1'b0, acc);
        chk1("bp_issue0", acc, 1'b1);
        cyc(1'b1, 1'b1, mk(2, 0, 3, 3), DW'(32'hF0F0), '0, '0, DW'(32'hFF00), 1'b0, acc);
        chk1("bp_issue1", acc, 1'b1);
        cyc(1'b1, 1'b1, mk(3, 2, 3, 6), '0, '0, DW'(3), DW'(4), 1'b0, acc);
        chk1("bp_issue2", acc, 1'b1);
        cyc(1'b1, 1'b1, mk(6, 1, 7, 11), '0, DW'(32'h55), '0, '0, 1'b0, acc);
        chk1("bp_issue3", acc, 1'b1);
        chk1("bp_ready", output_ready, 1'b1);
        chk1("bp_input_ack_low", input_ack, 1'b0);
        idle(3, 1'b0);
        chk1("bp_hold_ready", output_ready, 1'b1);
        chk("bp_hold_first", OutputS, DW'(7));
        chk("bp_hold_no_overwrite", OutputW, '0);
        cyc(1'b1, 1'b1, mk(0, 0, 0, 0), DW'(1), '0, '0, '0, 1'b0, acc);
        chk1("bp_reject_while_stalled", acc, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1, 1'b1);
            idle(1, 1'b0);
        end
        chk1("bp_all_acked", output_ready, 1'b0);
        chk("bp_queue_empty", DW'(sbq.size()), '0);
        drain();

        // Internal register and feedback path
        cyc(1'b1, 1'b1, mk(4, 0, 1, 0), DW'(5), DW'(7), '0, '0, 1'b1, acc);
        cyc(1'b1, 1'b1, mk(0, 0, 0, 14), '0, '0, '0, '0, 1'b1, acc);
        cyc(1'b1, 1'b1, mk(0, 0, 0, 15), '0, '0, '0, '0, 1'b1, acc);
        drain();
        chk1("int_no_ready", output_ready, 1'b0);
        cyc(1'b1, 1'b1, mk(6, 4, 7, 11), '0, '0, '0, '0, 1'b1, acc);
        drain();
        chk("int_Data_memory", Data_memory, DW'(12));
        cyc(1'b1, 1'b1, mk(7, 6, 6, 0), '0, '0, '0, '0, 1'b1, acc);
        drain();
        chk("fb_OutputE", OutputE, DW'(24));
        chk("fb_OutputN", OutputN, DW'(24));

        // Wrap and signed behaviour
        cyc(1'b1, 1'b1, mk(0, 0, 1, 0), DW'(32'hFFFF_FFFF), DW'(1), '0, '0, 1'b1, acc);
        cyc(1'b1, 1'b1, mk(1, 0, 1, 8), DW'(32'h8000_0000), DW'(4), '0, '0, 1'b1, acc);
        cyc(1'b1, 1'b1, mk(2, 0, 1, 13), DW'(32'hFFFF_FFFF), DW'(1), '0, '0, 1'b1, acc);
        drain();
        chk("wrap_add", OutputE, '0);
        chk("sra", OutputS, DW'(32'hF800_0000));
        chk("lt_signed", OutputW, DW'(1));

        // MUL: result with the multiplier, silent NOP without it
        cyc(1'b1, 1'b1, mk(3, 0, 1, 2), DW'(32'h1_0000), DW'(32'h1_0000), '0, '0, 1'b1, acc);
        idle(int'(LAT), 1'b1);
        chk1("mul_ready", output_ready, MUL_EN);
        drain();

        // Reset mid-flight discards both in-flight instructions
        cyc(1'b1, 1'b1, mk(0, 0, 1, 0), DW'(100), DW'(1), '0, '0, 1'b1, acc);
        cyc(1'b1, 1'b1, mk(3, 0, 1, 0), DW'(200), DW'(1), '0, '0, 1'b1, acc);
        do_reset(1);
        for (int i = 0; i < int'(LAT) + 2; i++) begin
            idle(1, 1'b0);
            chk1("midrst_no_retire", output_ready, 1'b0);
        end
        chk("midrst_OutputE", OutputE, '0);
        chk("midrst_OutputN", OutputN, '0);
        lat_test();
        drain();

        // Randomised traffic; register/feedback sources only when nothing is in flight
        drained = 1'b1;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                drain();
                drained = 1'b1;
            end else begin
                o1 = drained ? int'($urandom_range(0, 7)) : ext_src();
                o2 = drained ? int'($urandom_range(0, 7)) : ext_src();
                c  = mk(int'($urandom_range(0, 7)), o1, o2, int'($urandom_range(0, 15)));
                cyc($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, c,
                    rnd_val(), rnd_val(), rnd_val(), rnd_val(),
                    $urandom_range(0, 2) != 0, acc);
                if (acc) drained = 1'b0;
            end
        end
        drain();
        chk("final_queue_empty", DW'(sbq.size()), '0);
        chk1("final_no_pending", output_ready, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
